fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS datapath. Holds the PC, fetches instruction words over a request/acknowledge memory port, and presents the current instruction to the main control decoder, split into opcode and funct fields. Branch and jump resolution signals (beq, bne, jump, ALU zero) come back in the cycle the instruction is consumed and select the next PC. There is no speculation: the next fetch is issued only after the current instruction retires.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk, in, 1: single clock; everything is rising-edge.
- reset, in, 1: asynchronous, active-high.
- imem_req, out, 1: fetch request.
- imem_addr, out, 32: fetch address; equals the PC.
- imem_ack, in, 1: read data valid this cycle.
- imem_rdata, in, 32: instruction word.
- instr, out, 32: held instruction.
- opcode, out, 6: instr[31:26].
- funct, out, 6: instr[5:0].
- instr_valid, out, 1: instr/opcode/funct valid.
- instr_ready, in, 1: downstream consumes the instruction.
- pc_plus4, out, 32: PC+4 of the held instruction.
- beq, bne, jump, in, 1 each: decoded control for the held instruction; sampled only on handshake.
- zero, in, 1: ALU zero flag; sampled only on handshake.
- br_imm, in, 16: branch offset; sign-extended.
- jump_target, in, 26: jump index field.
- retire_count, out, 32: count of handshakes; wraps.

## Operation
- FSM states are IDLE, FETCH and HOLD.
  - IDLE: reset state. Always moves to FETCH on the next cycle.
  - FETCH: imem_req=1 with imem_addr=pc, both stable. When imem_ack=1: capture imem_rdata into instr and go to HOLD.
  - HOLD: instr_valid=1, imem_req=0, and instr is stable. When instr_valid & instr_ready: pc <= next_pc, retire_count += 1, go to FETCH.
- imem_ack is ignored outside FETCH.
- next_pc rules:
  - jump=1: {pc_plus4[31:28], jump_target, 2'b00}. Jump has priority over branches.
  - else (beq & zero) | (bne & ~zero): pc_plus4 + (sext(br_imm) << 2).
  - else: pc_plus4.
- Width rules: all adds are 32-bit modulo with no overflow detection, so 32'hFFFF_FFFC + 4 wraps to 0. The PC is always word-aligned by construction.
- Reset values (async, immediate): state=IDLE, pc=PC_RESET, imem_req=0, imem_addr=PC_RESET, instr=0, instr_valid=0, retire_count=0.
- Reset mid-operation: an outstanding request is abandoned and imem_req drops in the same cycle. Any ack arriving after reset is ignored.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- First request: imem_req=1 in the second cycle after reset deassertion (one cycle in IDLE).
- Ack in cycle N: instr_valid=1 in cycle N+1. Zero-wait ack (in the first FETCH cycle) is legal.
- Handshake in cycle M: imem_req=1 with the new address in cycle M+1.
- Peak throughput is one instruction per 2 cycles.
- Backpressure: instr_ready may stay low indefinitely. In HOLD, instr_ready is a don't-care until instr_valid=1.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_BNE=000101, OP_J=000010;
  - funct constants ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010;
  - the fetch_state enum {IDLE, FETCH, HOLD}.
- One combinational sub-module, `next_pc_calc`, computes next_pc from pc_plus4, beq, bne, jump, zero, br_imm and jump_target. This lets it be reused by a future pipelined fetch stage.

## Test plan
- Reset, PC_RESET=32'h0040_0000: release reset, expect imem_req=1 and imem_addr=32'h0040_0000 on the second cycle. Assert reset while FETCH is waiting: imem_req goes 0 immediately, and a later ack leaves instr_valid=0.
- Ack rdata=32'h012A_4020 with no branch: instr_valid=1, opcode=0, funct=6'h20. On handshake, the next imem_addr is 32'h0040_0004 and retire_count=1.
- beq at pc=32'h0040_0008 with br_imm=16'hFFFE:
  - zero=1 gives next addr 32'h0040_0004;
  - zero=0 gives 32'h0040_000C.
- bne=1, zero=0 at pc=32'h0040_0010 with br_imm=16'h0003: next addr 32'h0040_0020.
- jump=1 with jump_target=26'h010_0010 at pc=32'h0040_0020, also driving beq=1 and zero=1: next addr 32'h0040_0040 (jump wins).
- Ack after 3 wait cycles, then instr_ready low for 4 cycles: addr is stable through the wait, and during backpressure instr is stable, imem_req=0 and retire_count is unchanged. Zero-wait ack gives a steady 2-cycle cadence.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings and the fetch FSM states.
package mips_pkg;

   // Major opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] SLT = 6'b101010;

   // Fetch stage states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for a resolved instruction: jump, taken branch or fall-through.
// Purely combinational so a later pipelined fetch stage can reuse it as-is.
module next_pc_calc (
   input  logic [31:0] pc_plus4,
   input  logic        beq,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   input  logic [15:0] br_imm,
   input  logic [25:0] jump_target,
   output logic [31:0] next_pc
);

   logic [31:0] br_offset;
   logic        br_taken;

   // Word offset: sign-extend the 16-bit immediate and scale by 4
   assign br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};
   assign br_taken  = (beq & zero) | (bne & ~zero);

   // Jump wins over any branch; all adds wrap modulo 2^32
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      end else if (br_taken) begin
         next_pc = pc_plus4 + br_offset;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, request/ack memory port, held
// instruction for the decoder, and retirement counting. No speculation:
// the next fetch starts only after the held instruction is consumed.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc_plus4,
   input  logic        beq,
   input  logic        bne,
   input  logic        jump,
   input  logic        zero,
   input  logic [15:0] br_imm,
   input  logic [25:0] jump_target,
   output logic [31:0] retire_count
);

   fetch_state  state_reg;
   fetch_state  state_next;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic [31:0] count_reg;
   logic [31:0] next_pc;
   logic        capture;
   logic        retire;

   // Ack only counts while a request is outstanding; retire on the HOLD handshake
   assign capture = (state_reg == FETCH) & imem_ack;
   assign retire  = (state_reg == HOLD) & instr_ready;

   assign pc_plus4 = pc_reg + 32'd4;

   next_pc_calc u_next_pc (
      .pc_plus4    (pc_plus4),
      .beq         (beq),
      .bne         (bne),
      .jump        (jump),
      .zero        (zero),
      .br_imm      (br_imm),
      .jump_target (jump_target),
      .next_pc     (next_pc)
   );

   // State register; async reset abandons any outstanding request at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    state_next = FETCH;
         FETCH:   if (capture) state_next = HOLD;
         HOLD:    if (retire)  state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from the registered state only
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state_reg)
         FETCH:   imem_req    = 1'b1;
         HOLD:    instr_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: PC advances and the counter bumps on retire; instr loads on ack
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg    <= PC_RESET;
         instr_reg <= 32'd0;
         count_reg <= 32'd0;
      end else begin
         if (capture) begin
            instr_reg <= imem_rdata;
         end
         if (retire) begin
            pc_reg    <= next_pc;
            count_reg <= count_reg + 32'd1;
         end
      end
   end

   assign imem_addr    = pc_reg;
   assign instr        = instr_reg;
   assign opcode       = instr_reg[31:26];
   assign funct        = instr_reg[5:0];
   assign retire_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit: reset behaviour, branch/jump PC selection,
// wait states, backpressure and zero-wait cadence.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc_plus4;
   logic        beq, bne, jump, zero;
   logic [15:0] br_imm;
   logic [25:0] jump_target;
   logic [31:0] retire_count;

   int vectors    = 0;
   int miscompares = 0;
   int exp_count  = 0;

   fetch_unit #(.PC_RESET(32'h0040_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .opcode       (opcode),
      .funct        (funct),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .pc_plus4     (pc_plus4),
      .beq          (beq),
      .bne          (bne),
      .jump         (jump),
      .zero         (zero),
      .br_imm       (br_imm),
      .jump_target  (jump_target),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end else begin
         $display("ok   %s: %08h", tag, obs);
      end
   endtask

   // Advance one clock; all sampling and driving happens 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From FETCH: hold off ack for nwait cycles (address must stay put), then ack
   task automatic fetch(input logic [31:0] word, input int nwait, input logic [31:0] addr);
      for (int i = 0; i < nwait; i++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, addr);
         tick();
      end
      chk("fetch_addr", imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, word);
   endtask

   // From HOLD: handshake with the given control and check the next request
   task automatic retire_instr(input logic b_eq, input logic b_ne, input logic j,
                               input logic z, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic [31:0] exp_addr);
      beq = b_eq; bne = b_ne; jump = j; zero = z; br_imm = imm; jump_target = tgt;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0; br_imm = 16'h0; jump_target = 26'h0;
      exp_count++;
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, exp_addr);
      chk("retire_cnt", retire_count, exp_count);
   endtask

   initial begin
      logic [31:0] held;
      reset = 1'b1;
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0; br_imm = 16'h0; jump_target = 26'h0;
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0040_0000);
      chk("rst_instr", instr, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_count", retire_count, 32'd0);

      // Release: one cycle in IDLE, request in the second cycle
      reset = 1'b0;
      #1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0040_0000);

      // Reset while waiting in FETCH: request drops immediately, later ack ignored
      tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      chk("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
      reset = 1'b0;
      tick();
      imem_ack = 1'b0;
      chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("idle_ack_instr", instr, 32'd0);
      chk("refetch_req", {31'd0, imem_req}, 32'd1);

      // add $t0,$t1,$t2 then fall-through
      fetch(32'h012A_4020, 0, 32'h0040_0000);
      chk("opcode", {26'd0, opcode}, 32'd0);
      chk("funct", {26'd0, funct}, 32'h20);
      chk("pc_plus4", pc_plus4, 32'h0040_0004);
      retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0004);
      fetch(32'h8D09_0004, 0, 32'h0040_0004);
      chk("lw_opcode", {26'd0, opcode}, 32'h23);
      retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0008);

      // beq taken backwards
      fetch(32'h1109_FFFE, 0, 32'h0040_0008);
      chk("beq_opcode", {26'd0, opcode}, 32'h04);
      retire_instr(1, 0, 0, 1, 16'hFFFE, 26'h0, 32'h0040_0004);
      fetch(32'h0000_0000, 0, 32'h0040_0004);
      retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0008);
      // beq not taken
      fetch(32'h1109_FFFE, 0, 32'h0040_0008);
      retire_instr(1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0040_000C);
      fetch(32'h0000_0000, 0, 32'h0040_000C);
      retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0010);
      // bne taken forward
      fetch(32'h1509_0003, 0, 32'h0040_0010);
      retire_instr(0, 1, 0, 0, 16'h0003, 26'h0, 32'h0040_0020);
      // jump wins over a simultaneously-taken beq
      fetch(32'h0810_0010, 0, 32'h0040_0020);
      chk("j_opcode", {26'd0, opcode}, 32'h02);
      retire_instr(1, 0, 1, 1, 16'h0005, 26'h010_0010, 32'h0040_0040);

      // Three wait cycles, then four cycles of backpressure with stray acks
      fetch(32'h014B_6022, 3, 32'h0040_0040);
      held = 32'h014B_6022;
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000 + 32'(i);
         tick();
         chk("bp_instr", instr, held);
         chk("bp_req", {31'd0, imem_req}, 32'd0);
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_count", retire_count, exp_count);
      end
      imem_ack = 1'b0;
      retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0044);

      // Zero-wait acks: valid and req alternate every cycle
      for (int i = 0; i < 3; i++) begin
         fetch(32'h0000_0020 + 32'(i), 0, 32'h0040_0044 + 32'(4 * i));
         chk("cad_req_low", {31'd0, imem_req}, 32'd0);
         retire_instr(0, 0, 0, 0, 16'h0, 26'h0, 32'h0040_0048 + 32'(4 * i));
         chk("cad_valid_low", {31'd0, instr_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
